// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder: controller state
// encoding, nibble width and the index-width helper.
package nibble_add_seq_pkg;

    // Width of the single adder slice that is reused for every step.
    localparam int NIBBLE_W = 4;

    // Controller states. The encoding is also visible on the debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count nibble steps. A single-step build still
    // gets a 1-bit counter so the vector is never zero-width.
    function automatic int idx_width(input int nib);
        if (nib <= 1) begin
            return 1;
        end
        return $clog2(nib);
    endfunction

endpackage

// File: rtl/nibble_add_seq_slice.sv
// Combinational 4-bit ripple-carry adder slice made of 1-bit full adders.
// The controller holds all state; this block only adds one nibble.
module add_nibble_slice
    import nibble_add_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_out
);

    logic [NIBBLE_W:0] carry_w;

    // Ripple the carry through one full adder per bit.
    always_comb begin
        carry_w    = '0;
        sum        = '0;
        carry_w[0] = c_in;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]         = a[i] ^ b[i] ^ carry_w[i];
            carry_w[i + 1] = (a[i] & b[i]) | (carry_w[i] & (a[i] ^ b[i]));
        end
        c_out = carry_w[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial wide adder: one 4-bit slice is stepped across a WIDTH-bit
// operand pair, least significant nibble first, carry registered between
// steps. Handshake: start is accepted only in IDLE or DONE (operands and
// carry-in are captured on that edge); busy is high for the NIB RUN cycles;
// done is a one-cycle pulse in the cycle sum/c_out first hold the result.
// Optional macro NIBBLE_ADD_SEQ_SUB_EN adds a 'sub' input selecting a-b.
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [1:0]       dbg_state
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;

    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
    logic                slice_cout;
    logic [WIDTH-1:0]    b_cap;
    logic                carry_cap;
    int                  base;

    // Operand B and initial carry as stored on an accepted start;
    // subtraction stores ~b with a forced carry-in of 1.
    always_comb begin
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        b_cap     = sub ? ~b : b;
        carry_cap = sub ? 1'b1 : c_in;
`else
        b_cap     = b;
        carry_cap = c_in;
`endif
    end

    // Select the current nibble of each stored operand.
    always_comb begin
        base    = NIBBLE_W * int'(idx_q);
        slice_a = a_q[base +: NIBBLE_W];
        slice_b = b_q[base +: NIBBLE_W];
    end

    add_nibble_slice u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    // Next-state logic: capture on start, one nibble per RUN cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_cap;
                    carry_d = carry_cap;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[base +: NIBBLE_W] = slice_sum;
                carry_d                 = slice_cout;
                if (idx_q == IDX_LAST) begin
                    c_out_d = slice_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: a per-cycle arithmetic model of
// the 16-bit build (prefix sums of a+b+c_in), an expected-result queue
// popped on every done pulse, directed literal cases, and a 4-bit build.
module tb_nibble_add_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             c_in;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  logic             sub;
  logic             sub4;
`endif
  logic             busy, done, c_out;
  logic [WIDTH-1:0] sum;
  logic [1:0]       dbg_state;

  logic             start4, c4, busy4, done4, cout4;
  logic [3:0]       a4, b4, sum4;
  logic [1:0]       dbg4;

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_add_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .dbg_state(dbg_state)
  );

  nibble_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(c4),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    .sub(sub4),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .dbg_state(dbg4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Operation progress is tracked as "RUN cycles left"; after k steps the
  // low 4k bits of sum equal the low 4k bits of the full result.
  logic [WIDTH:0]   m_full;
  logic [WIDTH:0]   m_tmp;
  int               m_left;
  int               m_k;
  logic             m_busy, m_done, m_cout;
  logic [WIDTH-1:0] m_sum;
  logic [WIDTH:0]   exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_k   = NIB - m_left + 1;
      m_tmp = m_full & (((WIDTH + 1)'(1) << (4 * m_k)) - 1'b1);
      m_sum = m_tmp[WIDTH-1:0];
      if (m_left == 1) begin
        m_cout = m_full[WIDTH];
        m_done = 1;
      end
      m_left = m_left - 1;
    end else if (start) begin
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      if (sub) m_full = {1'b0, a} + {1'b0, ~b} + 1'b1;
      else     m_full = {1'b0, a} + {1'b0, b} + c_in;
`else
      m_full = {1'b0, a} + {1'b0, b} + c_in;
`endif
      m_sum  = '0;
      m_left = NIB;
      m_done = 0;
      exp_q.push_back(m_full);
    end else begin
      m_done = 0;
    end
    m_busy = (m_left > 0);
  end

  // ---------------- scoreboard compare ----------------
  logic [WIDTH:0] popped;
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("sum", sum, m_sum);
    chk("c_out", c_out, m_cout);
    if (m_done) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_nonempty", 0, 1);
      end else begin
        popped = exp_q.pop_front();
        chk("result", {c_out, sum}, popped);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic kick(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic cv, input logic sv, input bit hold);
    a = av; b = bv; c_in = cv; start = 1'b1;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub requested without subtract build");
`endif
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  // Returns at the falling edge of the done cycle.
  task automatic wait_for_done(input string name);
    int edges;
    bit found;
    edges = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    chk({name, "_done_seen"}, 32'(found), 1);
    if (found) chk({name, "_latency"}, edges, NIB);
  endtask

  task automatic expect_result(input string name, input logic [WIDTH-1:0] es, input logic ec);
    wait_for_done(name);
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, c_out, ec);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int edges4;
    bit found4;
    rst = 1; start = 0; a = '0; b = '0; c_in = 0;
    start4 = 0; a4 = '0; b4 = '0; c4 = 0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    sub = 0; sub4 = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1 rst = 0;

    // basic add, then back-to-back start in the DONE cycle
    @(posedge clk); #1;
    kick(16'h1234, 16'h0FFF, 0, 0, 0);
    expect_result("add_1234_0fff", 16'h2233, 0);
    kick(16'h0001, 16'h0002, 0, 0, 0);
    expect_result("b2b_1_2", 16'h0003, 0);

    // full carry ripple
    @(posedge clk); #1;
    kick(16'hFFFF, 16'h0001, 0, 0, 0);
    expect_result("ripple_ffff_1", 16'h0000, 1);

    // reset at idx=2 while c_out still holds 1
    @(posedge clk); #1;
    kick(16'h1234, 16'h1111, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_sum", sum, 16'h0045);
    rst = 1; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", c_out, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 0);
    end
    @(posedge clk); #1;
    kick(16'h0005, 16'h0006, 1, 0, 0);
    expect_result("after_rst", 16'h000C, 0);

    // carry-in propagates
    @(posedge clk); #1;
    kick(16'h00FF, 16'h0000, 1, 0, 0);
    expect_result("cin_00ff", 16'h0100, 0);

    // start held through RUN, operands changed mid-operation
    @(posedge clk); #1;
    kick(16'h1234, 16'h0FFF, 0, 0, 1);
    a = 16'hAAAA; b = 16'h0001; c_in = 0;
    expect_result("hold_first", 16'h2233, 0);
    @(posedge clk); #1;
    start = 0;
    a = 16'h5555; b = 16'h5555;
    expect_result("hold_second", 16'hAAAB, 0);

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    @(posedge clk); #1;
    kick(16'h0005, 16'h0007, 0, 1, 0);
    expect_result("sub_5_7", 16'hFFFE, 0);
    @(posedge clk); #1;
    kick(16'h0007, 16'h0005, 0, 1, 0);
    expect_result("sub_7_5", 16'h0002, 1);
    @(posedge clk); #1;
    kick(16'h1234, 16'h0FFF, 0, 0, 0);
    expect_result("sub0_add", 16'h2233, 0);
`endif

    // WIDTH=4 build: single RUN cycle
    @(posedge clk); #1;
    a4 = 4'h9; b4 = 4'h8; c4 = 1; start4 = 1;
    @(posedge clk); #1;
    start4 = 0; a4 = 4'h0; b4 = 4'h0; c4 = 0;
    edges4 = 0; found4 = 0;
    for (int i = 0; i < 10 && !found4; i++) begin
      @(negedge clk);
      if (done4) found4 = 1;
      else begin
        @(posedge clk);
        edges4++;
      end
    end
    chk("w4_done_seen", 32'(found4), 1);
    chk("w4_latency", edges4, 1);
    chk("w4_sum", sum4, 4'h2);
    chk("w4_cout", cout4, 1);

    // randomized operations, some back-to-back, some with idle gaps
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
      end
      kick(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 0);
      wait_for_done("rand");
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // hard time limit
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
